// File: rtl/cc_expun_wbq_if.sv
// Expunge / writeback / lookup bundle for the eviction writeback queue.
// master: queue side; slave: tag ways, fill path and writeback consumer.
interface cc_expun_wbq_if #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 37,
  parameter int WAYS       = 4
);
  logic [WAYS-1:0]                 exp_en;
  logic [WAYS-1:0][ADDR_WIDTH-1:0] exp_addr;
  logic                            wb_valid;
  logic [ADDR_WIDTH-1:0]           wb_addr;
  logic                            wb_ready;
  logic                            chk_en;
  logic [ADDR_WIDTH-1:0]           chk_addr;
  logic                            chk_hit;
  logic                            fill_stall;
  logic                            ovf;
  logic [$clog2(DEPTH):0]          count;

  modport master (
    input  exp_en, exp_addr, wb_ready, chk_en, chk_addr,
    output wb_valid, wb_addr, chk_hit, fill_stall, ovf, count
  );

  modport slave (
    output exp_en, exp_addr, wb_ready, chk_en, chk_addr,
    input  wb_valid, wb_addr, chk_hit, fill_stall, ovf, count
  );
endinterface

// File: rtl/cc_expun_wbq.sv
// Eviction writeback queue: captures tag-way victim addresses, merges
// duplicates, issues writebacks over valid/ready, answers in-flight lookups.
// Ports: clk, rst (sync, active-high), bus (cc_expun_wbq_if.master).
module cc_expun_wbq #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 37,
  parameter int WAYS       = 4
) (
  input  logic          clk,
  input  logic          rst,
  cc_expun_wbq_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WAYS-1:0] W_ONE = WAYS'(1);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_stall;
  logic                  r_ovf;
  logic                  r_hit;

  logic                  w_pop;
  logic                  w_req;
  logic [ADDR_WIDTH-1:0] w_paddr;
  logic                  w_multi;
  logic                  w_merge;
  logic                  w_chk_m;
  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic [CW-1:0]         w_cnt_nxt;

  assign w_pop = (r_count != '0) && bus.wb_ready;

  // Lowest-index strobing way wins.
  always_comb begin
    w_req   = 1'b0;
    w_paddr = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.exp_en[i]) begin
        w_req   = 1'b1;
        w_paddr = bus.exp_addr[i];
      end
    end
  end

  assign w_multi = |(bus.exp_en & (bus.exp_en - W_ONE));

  // The head leaving this edge no longer counts as pending.
  always_comb begin
    w_merge = 1'b0;
    w_chk_m = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && !(w_pop && (PW'(i) == r_head))) begin
        if (r_addr[i] == w_paddr)      w_merge = 1'b1;
        if (r_addr[i] == bus.chk_addr) w_chk_m = 1'b1;
      end
    end
  end

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push    = w_req && !w_merge && (!w_full || w_pop);
  assign w_drop    = w_req && !w_merge && w_full && !w_pop;
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
      r_ovf   <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      // Full push+pop hits the same slot; the push must win.
      if (w_push) begin
        r_addr[r_tail] <= w_paddr;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= r_tail + 1'b1;
      end
      r_count <= w_cnt_nxt;
      r_stall <= (w_cnt_nxt >= CW'(DEPTH - 1));
      r_ovf   <= r_ovf | w_multi | w_drop;
      r_hit   <= bus.chk_en &&
                 (w_chk_m || (w_push && (bus.chk_addr == w_paddr)));
    end
  end

  assign bus.wb_valid   = (r_count != '0);
  assign bus.wb_addr    = r_addr[r_head];
  assign bus.chk_hit    = r_hit;
  assign bus.fill_stall = r_stall;
  assign bus.ovf        = r_ovf;
  assign bus.count      = r_count;
endmodule

// File: tb/tb_cc_expun_wbq.sv
// Self-checking bench for cc_expun_wbq: directed steps then random traffic
// compared against a queue-based reference model.
module tb_cc_expun_wbq;
  localparam int DEPTH = 8;
  localparam int AW    = 37;
  localparam int WAYS  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cc_expun_wbq_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .WAYS(WAYS)) bus ();

  cc_expun_wbq #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .WAYS(WAYS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [AW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_hit = 1'b0;
  logic          m_rst = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one edge of behaviour computed from the current inputs.
  task automatic model_step();
    logic          pop, req, merged, accept;
    logic [AW-1:0] pa;
    int            first;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_hit = 1'b0;
      m_rst = 1'b1;
      return;
    end
    m_rst = 1'b0;
    pop   = (q.size() > 0) && bus.wb_ready;
    first = pop ? 1 : 0;
    req   = 1'b0;
    pa    = '0;
    for (int w = 0; w < WAYS; w++)
      if (!req && bus.exp_en[w]) begin
        req = 1'b1;
        pa  = bus.exp_addr[w];
      end
    if ($countones(bus.exp_en) > 1) m_ovf = 1'b1;
    merged = 1'b0;
    for (int k = first; k < q.size(); k++)
      if (q[k] == pa) merged = 1'b1;
    accept = req && !merged && (q.size() < DEPTH || pop);
    if (req && !merged && !accept) m_ovf = 1'b1;
    m_hit = 1'b0;
    if (bus.chk_en) begin
      for (int k = first; k < q.size(); k++)
        if (q[k] == bus.chk_addr) m_hit = 1'b1;
      if (accept && pa == bus.chk_addr) m_hit = 1'b1;
    end
    if (pop) void'(q.pop_front());
    if (accept) q.push_back(pa);
  endtask

  task automatic check_all();
    chk("count", 64'(bus.count), 64'(q.size()));
    chk("wb_valid", 64'(bus.wb_valid), 64'(q.size() > 0));
    chk("fill_stall", 64'(bus.fill_stall), 64'(q.size() >= DEPTH - 1));
    chk("ovf", 64'(bus.ovf), 64'(m_ovf));
    chk("chk_hit", 64'(bus.chk_hit), 64'(m_hit));
    if (q.size() > 0) chk("wb_addr", 64'(bus.wb_addr), 64'(q[0]));
    else if (m_rst) chk("wb_addr_rst", 64'(bus.wb_addr), 64'd0);
  endtask

  // Inputs change at posedge; the DUT samples them at the next negedge.
  task automatic step();
    model_step();
    @(negedge clk);
    @(posedge clk);
    check_all();
  endtask

  task automatic idle();
    bus.exp_en   = '0;
    bus.exp_addr = '0;
    bus.chk_en   = 1'b0;
    bus.chk_addr = '0;
  endtask

  task automatic push1(input int way, input logic [AW-1:0] a);
    bus.exp_en           = '0;
    bus.exp_en[way]      = 1'b1;
    bus.exp_addr[way]    = a;
  endtask

  initial begin
    idle();
    bus.wb_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // 1: single push, then pop
    push1(1, 37'h0_1234_5678);
    step();
    chk("t1_addr", 64'(bus.wb_addr), 64'h0_1234_5678);
    chk("t1_cnt", 64'(bus.count), 64'd1);
    idle();
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    chk("t1_empty", 64'(bus.wb_valid), 64'd0);

    // 2: fill, overflow drop, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      push1(0, AW'('h10 + i));
      step();
      chk("t2_stall", 64'(bus.fill_stall), 64'(i + 1 >= DEPTH - 1));
    end
    push1(0, AW'('h18));
    step();
    chk("t2_ovf", 64'(bus.ovf), 64'd1);
    chk("t2_full", 64'(bus.count), 64'(DEPTH));
    idle();
    bus.wb_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_order", 64'(bus.wb_addr), 64'('h10 + i));
      step();
    end
    bus.wb_ready = 1'b0;
    chk("t2_ovf_sticky", 64'(bus.ovf), 64'd1);

    // 3: push+pop while full, pointers wrap
    for (int i = 0; i < DEPTH; i++) begin
      push1(2, AW'('h100 + i));
      step();
    end
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push1(3, AW'('h200 + i));
      step();
      chk("t3_cnt", 64'(bus.count), 64'(DEPTH));
    end
    idle();
    for (int i = 0; i < DEPTH; i++) step();
    bus.wb_ready = 1'b0;

    // 4: merge, and the same-edge-pop exception
    push1(0, AW'('h30));
    step();
    step();
    chk("t4_merge", 64'(bus.count), 64'd1);
    idle();
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    push1(0, AW'('h30));
    step();
    bus.wb_ready = 1'b1;
    step();
    chk("t4_repush", 64'(bus.count), 64'd1);
    idle();
    step();
    bus.wb_ready = 1'b0;

    // 5: lookup
    push1(1, AW'('h40));
    step();
    idle();
    bus.chk_en   = 1'b1;
    bus.chk_addr = AW'('h40);
    step();
    chk("t5_hit", 64'(bus.chk_hit), 64'd1);
    bus.chk_addr = AW'('h41);
    step();
    chk("t5_miss", 64'(bus.chk_hit), 64'd0);
    bus.chk_addr = AW'('h40);
    bus.wb_ready = 1'b1;
    step();
    chk("t5_popmiss", 64'(bus.chk_hit), 64'd0);
    bus.wb_ready = 1'b0;
    idle();

    // 6: multi-strobe, then reset with entries pending
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.exp_en      = 4'b0101;
    bus.exp_addr[0] = AW'('h50);
    bus.exp_addr[2] = AW'('h51);
    step();
    chk("t6_sel", 64'(bus.wb_addr), 64'h50);
    chk("t6_ovf", 64'(bus.ovf), 64'd1);
    push1(0, AW'('h52));
    step();
    push1(0, AW'('h53));
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_cnt", 64'(bus.count), 64'd0);
    chk("t6_rst_ovf", 64'(bus.ovf), 64'd0);

    // Random traffic from a small address pool to force merges and hits
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.exp_en = ($urandom_range(0, 2) == 0) ? WAYS'($urandom) : '0;
      for (int w = 0; w < WAYS; w++)
        bus.exp_addr[w] = AW'($urandom_range(0, 15));
      bus.wb_ready = ($urandom_range(0, 2) == 0);
      bus.chk_en   = $urandom_range(0, 1) == 1;
      bus.chk_addr = AW'($urandom_range(0, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
